// File: rtl/dff_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_share_pkg
// Description : Command codes, FSM states and helpers for dff_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_share_pkg;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_SET   = 2'b10;
    localparam logic [1:0] CMD_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    // Pointer width that still works when NREQ is not a power of two.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_share_arbiter_if
// Description : Requester-side bus of the shared-register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     cmd;
    logic [WIDTH*NREQ-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    modport master (output req, cmd, wdata, input gnt, ack, q, busy);
    modport slave  (input req, cmd, wdata, output gnt, ack, q, busy);
endinterface
`default_nettype wire

// File: rtl/dff_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, search starts at ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dff_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] w_cand;

    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        // ptr itself is visited last so the previous grantee has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = PW'((int'(ptr) + k) % NREQ);
            if (!valid && req[w_cand]) begin
                winner[w_cand] = 1'b1;
                idx            = w_cand;
                valid          = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_share_arbiter
// Description : Round-robin owner of one shared clear/preset/load register.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              Rs,
    dff_share_arbiter_if.slave bus
);

    localparam int PW = ptr_width(NREQ);

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_sel;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;
    logic [WIDTH-1:0] r_q;

    logic [NREQ-1:0]  w_winner;
    logic [PW-1:0]    w_idx;
    logic             w_valid;
    logic [1:0]       w_cmd;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_q_next;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .idx    (w_idx),
        .valid  (w_valid)
    );

    assign w_cmd   = bus.cmd[2*r_sel +: 2];
    assign w_wdata = bus.wdata[WIDTH*r_sel +: WIDTH];

    always_comb begin
        w_q_next = r_q;
        case (w_cmd)
            CMD_LOAD:  w_q_next = w_wdata;
            CMD_CLEAR: w_q_next = '0;
            CMD_SET:   w_q_next = '1;
            default:   w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge Rs) begin
        if (!Rs) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_sel   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= w_winner;
                        r_sel   <= w_idx;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_gnt <= '0;
                    // A grantee that lets go of req before completion aborts silently.
                    if (bus.req[r_sel]) begin
                        r_q     <= w_q_next;
                        r_ack   <= r_gnt;
                        r_ptr   <= r_sel;
                        r_state <= ST_ACK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    r_ack   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.ack  = r_ack;
    assign bus.q    = r_q;
    assign bus.busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dff_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_share_arbiter
// Description : Randomized bench against a transaction-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_share_arbiter;
    import dff_share_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic Rs;
    always #5 clk = ~clk;

    dff_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .Rs  (Rs),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side stimulus state
    logic [NREQ-1:0]  t_req;
    logic [1:0]       t_cmd  [NREQ];
    logic [WIDTH-1:0] t_data [NREQ];

    // Timeline model: absolute edge numbers of grant, ack and next IDLE sample
    int               edge_n, next_sample, g_edge, g_idx, a_edge, a_idx, m_ptr;
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  exp_gnt, exp_ack;
    logic             exp_busy;

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int step = 1; step <= NREQ; step++) begin
            int cand;
            cand = (last + step) % NREQ;
            if (r[cand]) return cand;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q         = '0;
        m_ptr       = NREQ - 1;
        g_edge      = -1;
        a_edge      = -1;
        next_sample = edge_n + 1;
        exp_gnt     = '0;
        exp_ack     = '0;
        exp_busy    = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        edge_n++;
        if (g_edge >= 0 && edge_n == g_edge + 1) begin
            if (t_req[g_idx]) begin
                case (t_cmd[g_idx])
                    CMD_LOAD:  m_q = t_data[g_idx];
                    CMD_CLEAR: m_q = '0;
                    CMD_SET:   m_q = '1;
                    default:   m_q = m_q;
                endcase
                m_ptr       = g_idx;
                a_edge      = edge_n;
                a_idx       = g_idx;
                next_sample = edge_n + 2;
            end else begin
                next_sample = edge_n + 1;
            end
            g_edge = -1;
        end else if (edge_n == next_sample) begin
            w = rr_winner(t_req, m_ptr);
            if (w >= 0) begin
                g_edge = edge_n;
                g_idx  = w;
            end else begin
                next_sample = edge_n + 1;
            end
        end
        exp_gnt  = (g_edge == edge_n) ? (NREQ'(1) << g_idx) : '0;
        exp_ack  = (a_edge == edge_n) ? (NREQ'(1) << a_idx) : '0;
        exp_busy = (exp_gnt != '0) || (exp_ack != '0);
    endtask

    task automatic apply();
        bus.req = t_req;
        for (int i = 0; i < NREQ; i++) begin
            bus.cmd[2*i +: 2]           = t_cmd[i];
            bus.wdata[WIDTH*i +: WIDTH] = t_data[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt",  32'(bus.gnt),  32'(exp_gnt));
        chk("ack",  32'(bus.ack),  32'(exp_ack));
        chk("q",    32'(bus.q),    32'(m_q));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input logic [WIDTH-1:0] d);
        t_req[i]  = 1'b1;
        t_cmd[i]  = c;
        t_data[i] = d;
    endtask

    // Requesters hold while granted, usually drop on ack, sometimes re-request or abort.
    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (exp_ack[i]) begin
                if ($urandom_range(3) == 0)
                    set_req(i, 2'($urandom_range(3)), WIDTH'($urandom));
                else
                    t_req[i] = 1'b0;
            end else if (exp_gnt[i]) begin
                if ($urandom_range(7) == 0) t_req[i] = 1'b0;
            end else if (!t_req[i] && $urandom_range(2) == 0) begin
                set_req(i, 2'($urandom_range(3)), WIDTH'($urandom));
            end
        end
        apply();
    endtask

    initial begin
        edge_n = 0;
        a_idx  = 0;
        g_idx  = 0;
        t_req  = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_cmd[i]  = CMD_HOLD;
            t_data[i] = '0;
        end
        apply();
        Rs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",    32'(bus.q),    32'h0);
        chk("rst_gnt",  32'(bus.gnt),  32'h0);
        chk("rst_ack",  32'(bus.ack),  32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        Rs = 1'b1;
        model_reset();

        // Single LOAD from requester 0
        set_req(0, CMD_LOAD, 8'hA5);
        apply();
        cycle();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        cycle();
        chk("t1_q",   32'(bus.q),   32'hA5);
        chk("t1_ack", 32'(bus.ack), 32'h1);
        t_req[0] = 1'b0;
        apply();
        cycle();
        chk("t1_idle", 32'(bus.busy), 32'h0);

        repeat (2000) begin
            drive_random();
            cycle();
        end

        // Reset in the middle of a grant
        t_req = '0;
        apply();
        repeat (3) cycle();
        set_req(2, CMD_LOAD, 8'h3C);
        apply();
        cycle();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
        #2;
        Rs = 1'b0;
        #1;
        chk("arst_q",    32'(bus.q),    32'h0);
        chk("arst_gnt",  32'(bus.gnt),  32'h0);
        chk("arst_ack",  32'(bus.ack),  32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        t_req = '0;
        apply();
        repeat (2) @(posedge clk);
        @(negedge clk);
        Rs = 1'b1;
        model_reset();
        set_req(0, CMD_SET, 8'h00);
        set_req(3, CMD_LOAD, 8'h77);
        apply();
        cycle();
        chk("post_rst_gnt", 32'(bus.gnt), 32'h1);

        repeat (500) begin
            drive_random();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
